// File: rtl/div_pkg.sv
// Shared constants and types for the divider job scheduler.
// Status codes follow the encoding presented on res_status.
package div_pkg;
    localparam int DIV_W = 10;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_DVZ = 2'b01;
    localparam logic [1:0] ST_OVF = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;
endpackage

// File: rtl/div_op_fifo.sv
// Synchronous operand FIFO, power-of-two depth, registered occupancy count.
// Push on full and pop on empty are ignored; clr empties it synchronously.
module div_op_fifo #(
    parameter int DW    = 20,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/div_job_scheduler.sv
// Feeder/collector for the sequential divider: queues operand pairs, runs one
// job at a time with a watchdog, and returns quotient + status on ready/valid.
//
//   state   | meaning
//   S_IDLE  | no job; leave when the FIFO holds a pair
//   S_ISSUE | one cycle: div_start pulse, operands presented, FIFO head popped
//   S_WAIT  | waiting for divider completion or watchdog expiry
//   S_DONE  | result presented on res_valid until res_ready
module div_job_scheduler
    import div_pkg::*;
#(
    parameter int W       = DIV_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sclr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_q,
    output logic [1:0]   res_status,
    output logic         div_start,
    output logic         div_sclr,
    output logic [W-1:0] div_a,
    output logic [W-1:0] div_b,
    input  logic         div_busy,
    input  logic         div_valid,
    input  logic         div_dvz,
    input  logic         div_ovf,
    input  logic [W-1:0] div_q,
    output logic [15:0]  job_cnt,
    output logic [15:0]  err_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(DEPTH + 1);

    state_t         state;
    state_t         next_state;
    logic [TW-1:0]  timer;
    logic [2*W-1:0] head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count_unused;
    logic           push;
    logic           pop;
    logic           div_done;
    logic           load_ops;
    logic           finish;
    logic [W-1:0]   fin_q;
    logic [1:0]     fin_status;
    logic           unused_busy;

    assign unused_busy = div_busy;

    assign in_ready  = ~fifo_full;
    assign res_valid = (state == S_DONE);
    assign push      = in_valid & in_ready & ~sclr;
    assign pop       = (state == S_ISSUE) & ~sclr;

    // The divider may still show flags from the previous job in the first WAIT cycle.
    assign div_done  = (timer != '0) & (div_dvz | div_ovf | div_valid);

    div_op_fifo #(
        .DW    (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (sclr),
        .push  (push),
        .pop   (pop),
        .wdata ({in_a, in_b}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    always_comb begin
        next_state = state;
        div_start  = 1'b0;
        div_sclr   = 1'b0;
        load_ops   = 1'b0;
        finish     = 1'b0;
        fin_q      = '0;
        fin_status = ST_OK;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    next_state = S_ISSUE;
                    load_ops   = 1'b1;
                end
            end
            S_ISSUE: begin
                div_start  = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (div_done) begin
                    next_state = S_DONE;
                    finish     = 1'b1;
                    if (div_dvz) begin
                        fin_status = ST_DVZ;
                    end else begin
                        fin_q      = div_q;
                        fin_status = div_ovf ? ST_OVF : ST_OK;
                    end
                end else if (timer == TW'(TIMEOUT)) begin
                    next_state = S_DONE;
                    finish     = 1'b1;
                    div_sclr   = 1'b1;
                    fin_status = ST_TMO;
                end
            end
            S_DONE: begin
                if (res_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        // Flush overrides everything; only a live job needs the divider cleared.
        if (sclr) begin
            next_state = S_IDLE;
            div_start  = 1'b0;
            load_ops   = 1'b0;
            finish     = 1'b0;
            div_sclr   = (state == S_ISSUE) || (state == S_WAIT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            timer      <= '0;
            div_a      <= '0;
            div_b      <= '0;
            res_q      <= '0;
            res_status <= ST_OK;
            job_cnt    <= '0;
            err_cnt    <= '0;
        end else begin
            state <= next_state;
            timer <= (state == S_WAIT && next_state == S_WAIT) ? timer + 1'b1 : '0;
            if (load_ops) {div_a, div_b} <= head;
            if (finish) begin
                res_q      <= fin_q;
                res_status <= fin_status;
                job_cnt    <= job_cnt + 16'd1;
                if (fin_status != ST_OK && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_div_job_scheduler.sv
// Directed bench for div_job_scheduler with a behavioural divider and a
// queue-based scoreboard that predicts every result from the operands.
`timescale 1ns/1ps
module tb_div_job_scheduler;
    import div_pkg::*;

    localparam int W       = 10;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int DLAT    = 11;

    typedef enum int {M_NORM, M_HANG, M_EARLY, M_OVF} mode_t;
    typedef struct packed {
        logic [W-1:0] q;
        logic [1:0]   st;
    } res_t;

    logic         clk = 1'b0;
    logic         rst, sclr, in_valid, in_ready, res_valid, res_ready;
    logic         div_start, div_sclr, div_busy, div_valid, div_dvz, div_ovf;
    logic [W-1:0] in_a, in_b, res_q, div_a, div_b, div_q;
    logic [1:0]   res_status;
    logic [15:0]  job_cnt, err_cnt;
    mode_t        div_mode;
    logic         stray;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_job_scheduler #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .sclr(sclr),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q), .res_status(res_status),
        .div_start(div_start), .div_sclr(div_sclr), .div_a(div_a), .div_b(div_b),
        .div_busy(div_busy), .div_valid(div_valid), .div_dvz(div_dvz), .div_ovf(div_ovf),
        .div_q(div_q), .job_cnt(job_cnt), .err_cnt(err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural divider: fixed latency, flags pulse for one cycle.
    logic         dm_busy;
    int           dm_cnt;
    logic [W-1:0] dm_a, dm_b;
    mode_t        dm_mode;
    assign div_busy = dm_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_busy <= 1'b0; dm_cnt <= 0; dm_mode <= M_NORM;
            dm_a <= '0; dm_b <= '0;
            div_valid <= 1'b0; div_dvz <= 1'b0; div_ovf <= 1'b0; div_q <= '0;
        end else begin
            div_valid <= 1'b0; div_dvz <= 1'b0; div_ovf <= 1'b0;
            if (stray) begin div_valid <= 1'b1; div_dvz <= 1'b1; end
            if (div_sclr) begin
                dm_busy <= 1'b0;
            end else if (div_start) begin
                dm_busy <= 1'b1; dm_cnt <= DLAT; dm_a <= div_a; dm_b <= div_b; dm_mode <= div_mode;
                if (div_mode == M_EARLY) begin div_valid <= 1'b1; div_q <= 10'h155; end
            end else if (dm_busy && dm_mode != M_HANG && dm_mode != M_EARLY) begin
                if (dm_cnt == 0) begin
                    dm_busy <= 1'b0;
                    if (dm_b == '0) begin
                        div_dvz <= 1'b1; div_q <= '1;
                        if (dm_mode == M_OVF) begin div_ovf <= 1'b1; div_valid <= 1'b1; end
                    end else begin
                        div_q <= dm_a / dm_b; div_valid <= 1'b1;
                        if (dm_mode == M_OVF) div_ovf <= 1'b1;
                    end
                end else begin
                    dm_cnt <= dm_cnt - 1;
                end
            end
        end
    end

    function automatic res_t expect_of(input logic [2*W-1:0] ab, input mode_t m);
        res_t r;
        logic [W-1:0] a, b;
        a = ab[2*W-1:W];
        b = ab[W-1:0];
        if (m == M_HANG || m == M_EARLY) begin r.q = '0; r.st = ST_TMO; end
        else if (b == '0)                begin r.q = '0; r.st = ST_DVZ; end
        else begin r.q = a / b; r.st = (m == M_OVF) ? ST_OVF : ST_OK; end
        return r;
    endfunction

    // Scoreboard: pending operand queue, expected results, completion counts.
    logic [2*W-1:0] pend[$];
    res_t           expq[$];
    int             n_done = 0;
    int             n_err  = 0;
    int             start_cyc = 0;
    bit             hang_active = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", in_ready, pend.size() < DEPTH);
            if (res_valid) begin
                chk("start_in_done", div_start, 0);
                if (expq.size() == 0) begin
                    chk("res_spurious", res_valid, 0);
                end else begin
                    chk("res_q", res_q, expq[0].q);
                    chk("res_status", res_status, expq[0].st);
                    chk("job_cnt", job_cnt, 16'(n_done + 1));
                    chk("err_cnt", err_cnt, n_err + (expq[0].st != ST_OK));
                    if (res_ready) begin
                        n_done++;
                        if (expq[0].st != ST_OK) n_err++;
                        void'(expq.pop_front());
                    end
                end
            end
            if (hang_active && cyc == start_cyc + TIMEOUT + 1) begin
                chk("tmo_sclr", div_sclr, 1);
                hang_active = 1'b0;
            end else if (div_sclr && !sclr) begin
                chk("div_sclr_unexp", div_sclr, 0);
            end
            if (div_start) begin
                if (pend.size() == 0) begin
                    chk("start_empty", div_start, 0);
                end else begin
                    chk("div_a", div_a, pend[0][2*W-1:W]);
                    chk("div_b", div_b, pend[0][W-1:0]);
                    expq.push_back(expect_of(pend[0], div_mode));
                    void'(pend.pop_front());
                    if (div_mode == M_HANG || div_mode == M_EARLY) begin
                        hang_active = 1'b1;
                        start_cyc   = cyc;
                    end
                end
            end
            if (in_valid && in_ready && !sclr) pend.push_back({in_a, in_b});
            if (sclr) begin
                pend.delete();
                expq.delete();
                hang_active = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        int   n;
        logic got;
        n = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        do begin
            @(negedge clk); got = in_ready;
            @(posedge clk); #1; n++;
        end while (!got && n < 200);
        if (!got) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_res(input int lim);
        int n;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < lim) begin @(negedge clk); n++; end
        if (!res_valid) chk("res_timeout", 0, 1);
    endtask

    task automatic wait_start(input int lim);
        int n;
        n = 0;
        @(negedge clk);
        while (!div_start && n < lim) begin @(negedge clk); n++; end
        if (!div_start) chk("start_timeout", 0, 1);
    endtask

    task automatic wait_drain(input int lim);
        int n;
        n = 0;
        while ((pend.size() != 0 || expq.size() != 0) && n < lim) begin tick(); n++; end
        if (pend.size() != 0 || expq.size() != 0) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; sclr = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        res_ready = 1'b1; div_mode = M_NORM; stray = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_div_sclr", div_sclr, 0);
        chk("rst_res_q", res_q, 0);
        chk("rst_jobs", job_cnt, 0);
        chk("rst_errs", err_cnt, 0);
        chk("rst_div_a", div_a, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Single job: start two cycles after the push, 100/7 = 14.
        push(10'd100, 10'd7); in_valid = 1'b0;
        @(negedge clk); chk("lat_c1", div_start, 0);
        @(negedge clk); chk("lat_c2", div_start, 1);
        wait_res(50);
        chk("t1_q", res_q, 14); chk("t1_st", res_status, ST_OK); chk("t1_jobs", job_cnt, 1);
        tick();

        // Divide by zero: quotient forced to zero even though divider drives all ones.
        push(10'd5, 10'd0); in_valid = 1'b0;
        wait_res(50);
        chk("t2_q", res_q, 0); chk("t2_st", res_status, ST_DVZ); chk("t2_errs", err_cnt, 1);
        tick();

        // Divider flags while idle must not produce a result.
        stray = 1'b1; repeat (3) tick(); stray = 1'b0;
        repeat (2) tick();
        @(negedge clk); chk("stray", res_valid, 0);
        tick();

        // Back-to-back fill with consumer stalled, then hold the first result.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(10'(10 * (i + 3)), 10'(i + 2));
        in_valid = 1'b0;
        @(negedge clk); chk("t3_full", in_ready, 0);
        wait_res(50);
        chk("t3_first_q", res_q, 15);
        for (int i = 0; i < 10; i++) begin @(negedge clk); chk("t6_hold", res_valid, 1); end
        tick(); res_ready = 1'b1;
        wait_drain(300);
        chk("t3_jobs", job_cnt, 7); chk("t3_errs", err_cnt, 1);

        // Status priority: ovf over valid, dvz over ovf.
        div_mode = M_OVF;
        push(10'd9, 10'd3); in_valid = 1'b0;
        wait_res(50);
        chk("ovf_q", res_q, 3); chk("ovf_st", res_status, ST_OVF);
        tick();
        push(10'd9, 10'd0); in_valid = 1'b0;
        wait_res(50);
        chk("dvz_pri_q", res_q, 0); chk("dvz_pri_st", res_status, ST_DVZ);
        tick(); div_mode = M_NORM;

        // Hung divider: watchdog abort, then the queued job still runs.
        div_mode = M_HANG;
        push(10'd50, 10'd5); in_valid = 1'b0;
        wait_start(20);
        tick(); div_mode = M_NORM;
        push(10'd60, 10'd6); in_valid = 1'b0;
        wait_res(120);
        chk("tmo_st", res_status, ST_TMO); chk("tmo_q", res_q, 0);
        tick();
        wait_res(50);
        chk("after_tmo_q", res_q, 10); chk("after_tmo_st", res_status, ST_OK);
        tick();

        // Completion pulse in the first WAIT cycle is ignored.
        div_mode = M_EARLY;
        push(10'd7, 10'd7); in_valid = 1'b0;
        wait_start(20);
        tick(); div_mode = M_NORM;
        wait_res(120);
        chk("early_st", res_status, ST_TMO);
        chk("early_jobs", job_cnt, 12); chk("early_errs", err_cnt, 5);
        tick();

        // Flush during WAIT with three queued; the simultaneous push is dropped.
        div_mode = M_HANG;
        push(10'd11, 10'd1); push(10'd12, 10'd2); push(10'd13, 10'd3); push(10'd14, 10'd4);
        in_valid = 1'b0;
        repeat (5) tick();
        div_mode = M_NORM;
        sclr = 1'b1; in_valid = 1'b1; in_a = 10'd99; in_b = 10'd9;
        @(negedge clk); chk("sclr_div_sclr", div_sclr, 1);
        @(posedge clk); #1 sclr = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("sclr_no_res", res_valid, 0);
            chk("sclr_no_start", div_start, 0);
            chk("sclr_ready", in_ready, 1);
        end
        tick();
        push(10'd20, 10'd4); in_valid = 1'b0;
        wait_res(50);
        chk("post_sclr_q", res_q, 5);
        chk("post_sclr_jobs", job_cnt, 13); chk("post_sclr_errs", err_cnt, 5);
        tick();
        wait_drain(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
